// File: rtl/task_sequencer_pkg.sv
// Shared types and default sizing for the task sequencer and its interrupt latch.
package task_sequencer_pkg;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StDrain  = 2'd1,
    StVector = 2'd2
  } state_e;

  localparam int unsigned DefStages = 3;
  localparam int unsigned DefIdW    = 3;

endpackage

// File: rtl/irq_latch.sv
// Interrupt sampling, optional per-ID masking, pending flag, latched ID and global enable.
// Build with QISP_IRQ_MASK_EN defined to add the per-ID mask register.
module irq_latch
  import task_sequencer_pkg::*;
#(
  parameter int unsigned ID_W = DefIdW
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 irq_i,
  input  logic [ID_W-1:0]      irq_id_i,
  input  logic                 en_set_i,
  input  logic                 en_clr_i,
  input  logic                 ret_i,
  input  logic                 mask_we_i,
  input  logic [2**ID_W-1:0]   mask_data_i,
  input  logic                 vector_i,
  output logic                 pending_o,
  output logic [ID_W-1:0]      id_o,
  output logic                 enabled_o
);

  logic            pending_q, pending_d;
  logic [ID_W-1:0] id_q, id_d;
  logic            enabled_q, enabled_d;
  logic            accept;

`ifdef QISP_IRQ_MASK_EN
  logic [2**ID_W-1:0] mask_q, mask_d;

  always_comb begin
    mask_d = mask_q;
    if (mask_we_i) mask_d = mask_data_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) mask_q <= '1;
    else         mask_q <= mask_d;
  end

  assign accept = mask_q[irq_id_i];
`else
  logic unused_mask;
  assign unused_mask = ^{mask_we_i, mask_data_i};
  assign accept      = 1'b1;
`endif

  always_comb begin
    pending_d = pending_q;
    id_d      = id_q;
    enabled_d = enabled_q;
    // Only one request is held at a time; later requests are dropped until vectored.
    if (vector_i) begin
      pending_d = 1'b0;
    end else if (irq_i && !pending_q && accept) begin
      pending_d = 1'b1;
      id_d      = irq_id_i;
    end
    if (vector_i)                 enabled_d = 1'b0;
    else if (en_clr_i)            enabled_d = 1'b0;
    else if (en_set_i || ret_i)   enabled_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pending_q <= 1'b0;
      id_q      <= '0;
      enabled_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      id_q      <= id_d;
      enabled_q <= enabled_d;
    end
  end

  assign pending_o = pending_q;
  assign id_o      = id_q;
  assign enabled_o = enabled_q;

endmodule

// File: rtl/task_sequencer.sv
// Task-selector pipeline that drains its stages and vectors a latched interrupt.
// QISP_IRQ_MASK_EN enables the per-ID interrupt mask inside irq_latch.
module task_sequencer
  import task_sequencer_pkg::*;
#(
  parameter int unsigned STAGES = DefStages,
  parameter int unsigned ID_W   = DefIdW
) (
  input  logic               clk,
  input  logic               a_rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               irq,
  input  logic [ID_W-1:0]    irq_id,
  input  logic               irq_en_set,
  input  logic               irq_en_clr,
  input  logic               irq_ret,
  input  logic               mask_we,
  input  logic [2**ID_W-1:0] mask_data,
  output logic [STAGES-1:0]  ts,
  output logic               irq_take,
  output logic [ID_W-1:0]    irq_vec,
  output logic               irq_enabled,
  output logic               irq_pending
);

  state_e            state_q, state_d;
  logic [STAGES-1:0] ts_q, ts_d;
  logic              take_q, take_d;
  logic [ID_W-1:0]   vec_q, vec_d;
  logic [ID_W-1:0]   latched_id;

  irq_latch #(
    .ID_W (ID_W)
  ) u_irq_latch (
    .clk_i       (clk),
    .rst_ni      (a_rst),
    .irq_i       (irq),
    .irq_id_i    (irq_id),
    .en_set_i    (irq_en_set),
    .en_clr_i    (irq_en_clr),
    .ret_i       (irq_ret),
    .mask_we_i   (mask_we),
    .mask_data_i (mask_data),
    .vector_i    (state_q == StVector),
    .pending_o   (irq_pending),
    .id_o        (latched_id),
    .enabled_o   (irq_enabled)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:    if (!stall && irq_pending && irq_enabled) state_d = StDrain;
      StDrain:  if (!stall && (ts_q[STAGES-1:1] == '0))   state_d = StVector;
      // The vector cycle always completes so irq_take stays a single-cycle pulse.
      StVector: state_d = StRun;
      default:  state_d = StRun;
    endcase
  end

  always_comb begin
    ts_d = ts_q;
    if (flush) begin
      ts_d    = '0;
      ts_d[0] = (state_d == StRun);
    end else if (!stall) begin
      ts_d = {ts_q[STAGES-2:0], (state_d == StRun)};
    end
    take_d = (state_d == StVector);
    vec_d  = take_d ? latched_id : '0;
  end

  always_ff @(posedge clk) begin
    if (!a_rst) begin
      state_q <= StRun;
      ts_q    <= '0;
      take_q  <= 1'b0;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_d;
      take_q  <= take_d;
      vec_q   <= vec_d;
    end
  end

  assign ts       = ts_q;
  assign irq_take = take_q;
  assign irq_vec  = vec_q;

endmodule

// File: tb/tb_task_sequencer.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_task_sequencer;

  localparam int unsigned STAGES = 3;
  localparam int unsigned ID_W   = 3;
  localparam int unsigned NID    = 2 ** ID_W;
  localparam int unsigned FULL   = (1 << STAGES) - 1;

  localparam int MRun = 0, MDrain = 1, MVector = 2;

  logic              clk = 1'b0;
  logic              a_rst, stall, flush, irq, irq_en_set, irq_en_clr, irq_ret, mask_we;
  logic [ID_W-1:0]   irq_id;
  logic [NID-1:0]    mask_data;
  logic [STAGES-1:0] ts;
  logic              irq_take, irq_enabled, irq_pending;
  logic [ID_W-1:0]   irq_vec;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          m_mode;
  int unsigned m_ts;
  bit          m_pend, m_en, m_take;
  int unsigned m_id, m_vec;
  bit [NID-1:0] m_mask;

  always #5 clk = ~clk;

  task_sequencer #(
    .STAGES (STAGES),
    .ID_W   (ID_W)
  ) dut (
    .clk         (clk),
    .a_rst       (a_rst),
    .stall       (stall),
    .flush       (flush),
    .irq         (irq),
    .irq_id      (irq_id),
    .irq_en_set  (irq_en_set),
    .irq_en_clr  (irq_en_clr),
    .irq_ret     (irq_ret),
    .mask_we     (mask_we),
    .mask_data   (mask_data),
    .ts          (ts),
    .irq_take    (irq_take),
    .irq_vec     (irq_vec),
    .irq_enabled (irq_enabled),
    .irq_pending (irq_pending)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock of the behaviour described by the requirements, using the pre-edge inputs.
  task automatic model_step();
    int  nxt;
    bit  vec_now, accept, fetch;
    if (!a_rst) begin
      m_mode = MRun; m_ts = 0; m_pend = 0; m_id = 0; m_en = 0;
      m_take = 0; m_vec = 0; m_mask = '1;
      return;
    end
    vec_now = (m_mode == MVector);
    nxt = m_mode;
    if (m_mode == MRun && !stall && m_pend && m_en) nxt = MDrain;
    else if (m_mode == MDrain && !stall && (m_ts >> 1) == 0) nxt = MVector;
    else if (m_mode == MVector) nxt = MRun;
    fetch = (nxt == MRun);
    if (flush)       m_ts = fetch ? 1 : 0;
    else if (!stall) m_ts = ((m_ts << 1) & FULL) | (fetch ? 1 : 0);
    m_take = (nxt == MVector);
    m_vec  = m_take ? m_id : 0;
`ifdef QISP_IRQ_MASK_EN
    accept = m_mask[irq_id];
    if (mask_we) m_mask = mask_data;
`else
    accept = 1'b1;
`endif
    if (vec_now) m_pend = 0;
    else if (irq && !m_pend && accept) begin
      m_pend = 1;
      m_id   = int'(irq_id);
    end
    if (vec_now || irq_en_clr)       m_en = 0;
    else if (irq_en_set || irq_ret)  m_en = 1;
    m_mode = nxt;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_eq("ts",      32'(ts),          32'(m_ts));
    check_eq("take",    32'(irq_take),    32'(m_take));
    check_eq("vec",     32'(irq_vec),     32'(m_vec));
    check_eq("enabled", 32'(irq_enabled), 32'(m_en));
    check_eq("pending", 32'(irq_pending), 32'(m_pend));
    @(negedge clk);
  endtask

  task automatic quiet();
    a_rst = 1'b1; stall = 1'b0; flush = 1'b0; irq = 1'b0; irq_id = '0;
    irq_en_set = 1'b0; irq_en_clr = 1'b0; irq_ret = 1'b0; mask_we = 1'b0; mask_data = '0;
  endtask

  initial begin
    quiet();
    a_rst = 1'b0;
    cycle();
    check_eq("rst_ts", 32'(ts), 32'h0);
    quiet();
    cycle(); check_eq("boot_ts0", 32'(ts), 32'h1);
    cycle(); check_eq("boot_ts1", 32'(ts), 32'h3);
    cycle(); check_eq("boot_ts2", 32'(ts), 32'h7);
    cycle(); check_eq("boot_ts3", 32'(ts), 32'h7);

    // Enable set and clear together: clear wins.
    irq_en_set = 1'b1; irq_en_clr = 1'b1; cycle();
    check_eq("set_clr_en", 32'(irq_enabled), 32'h0);
    quiet(); irq = 1'b1; irq_id = 3'd6; cycle(); quiet();
    cycle(); cycle();
    check_eq("disabled_no_drain", 32'(ts), 32'h7);
    irq_ret = 1'b1; cycle(); quiet();
    for (int i = 0; i < 6; i++) cycle();
    check_eq("ret_vectored", 32'(irq_pending), 32'h0);

    // Full drain and vector of ID 5.
    irq_en_set = 1'b1; cycle(); quiet();
    irq = 1'b1; irq_id = 3'd5; cycle(); quiet();
    cycle(); check_eq("drain0", 32'(ts), 32'h6);
    cycle(); check_eq("drain1", 32'(ts), 32'h4);
    cycle(); check_eq("drain2", 32'(ts), 32'h0);
    cycle(); check_eq("take", 32'(irq_take), 32'h1); check_eq("vec5", 32'(irq_vec), 32'h5);
    cycle(); check_eq("take_end", 32'(irq_take), 32'h0);
    check_eq("en_cleared", 32'(irq_enabled), 32'h0);
    check_eq("refetch", 32'(ts), 32'h1);

    // Stall and flush during drain.
    for (int i = 0; i < 3; i++) cycle();
    irq_en_set = 1'b1; irq = 1'b1; irq_id = 3'd2; cycle(); quiet();
    cycle();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(); check_eq("stall_ts", 32'(ts), 32'h6); check_eq("stall_take", 32'(irq_take), 32'h0);
    end
    stall = 1'b0; flush = 1'b1; cycle(); quiet();
    check_eq("flush_ts", 32'(ts), 32'h0);
    cycle(); check_eq("flush_take", 32'(irq_take), 32'h1);
    cycle();

    // Reset in the middle of a drain discards the request.
    for (int i = 0; i < 3; i++) cycle();
    irq_en_set = 1'b1; irq = 1'b1; irq_id = 3'd7; cycle(); quiet();
    cycle();
    a_rst = 1'b0; cycle(); quiet();
    check_eq("mid_rst_ts", 32'(ts), 32'h0);
    check_eq("mid_rst_pend", 32'(irq_pending), 32'h0);
    for (int i = 0; i < 6; i++) begin
      cycle(); check_eq("mid_rst_notake", 32'(irq_take), 32'h0);
    end

`ifdef QISP_IRQ_MASK_EN
    mask_we = 1'b1; mask_data = 8'hFD; irq_en_set = 1'b1; cycle(); quiet();
    irq = 1'b1; irq_id = 3'd1; cycle(); quiet();
    check_eq("masked_id1", 32'(irq_pending), 32'h0);
    irq = 1'b1; irq_id = 3'd2; cycle(); quiet();
    for (int i = 0; i < 5; i++) cycle();
    check_eq("mask_id2_vec", 32'(irq_vec), 32'h2);
    cycle();
`endif

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      a_rst      = ($urandom_range(99) != 0);
      stall      = ($urandom_range(99) < 15);
      flush      = ($urandom_range(99) < 10);
      irq        = ($urandom_range(99) < 30);
      irq_id     = ID_W'($urandom_range(NID - 1));
      irq_en_set = ($urandom_range(99) < 20);
      irq_en_clr = ($urandom_range(99) < 5);
      irq_ret    = ($urandom_range(99) < 5);
      mask_we    = ($urandom_range(99) < 5);
      mask_data  = NID'($urandom);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
